readout_scheduler: RTL and testbench
====================================

Name: readout_scheduler

Overview:
- Arbitrates the shared readout engine between two requesters: IPbus register commands (RTM path) and trigger-FIFO readouts (DTM path).
- Grants one requester at a time and holds its run level until the path reports done.
- Guarantees the trigger path is never starved, using a bounded IPbus streak.
- Watchdogs every transaction; on timeout it aborts and counts the error. Maintains the 32-bit command sequence number (csn).

Parameters:
- MAX_IPBUS_STREAK, 4: maximum consecutive RTM grants while a trigger readout is pending. Range 1..255.
- TIMEOUT_CYCLES, 65536: cycles a run may stay asserted without done before abort. Range 2..2^20.
- GAP_CYCLES, 2: idle cycles forced after every transaction or abort before the next grant. 0 means no gap.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  when low, no new grants; an in-flight transaction completes normally
- ipbus_cmd_valid  in  1  IPbus command pending (level)
- tm_fifo_valid  in  1  trigger FIFO non-empty (level)
- rtm_done  in  1  RTM path finished (1-cycle pulse)
- dtm_done  in  1  DTM path finished (1-cycle pulse)
- run_rtm  out  1  RTM path granted (level, registered)
- run_dtm  out  1  DTM path granted (level, registered)
- abort  out  1  one-cycle pulse when a transaction times out
- busy  out  1  high in any state other than IDLE
- csn  out  32  command sequence number; counts completed transactions
- timeout_cnt  out  16  number of aborts; saturates at 0xFFFF

Behaviour:
- Reset, asserted asynchronously: state=IDLE; every output 0; streak counter 0; watchdog 0; gap counter 0.
- States: IDLE, RUN_RTM, RUN_DTM, ABORT, GAP.
- Outputs decode directly from registered state:
  - run_rtm = (state==RUN_RTM)
  - run_dtm = (state==RUN_DTM)
  - abort = (state==ABORT)
  - busy = (state!=IDLE)
- Latency: a request sampled in IDLE in cycle N gives run_* high in cycle N+1.
- IDLE: if enable=0, stay. Otherwise:
  - Only ipbus_cmd_valid high -> RUN_RTM.
  - Only tm_fifo_valid high -> RUN_DTM.
  - Both high -> RUN_RTM if streak < MAX_IPBUS_STREAK, else RUN_DTM.
- Streak update, applied at the grant:
  - RTM grant with tm_fifo_valid=1: streak+1, saturating at MAX_IPBUS_STREAK.
  - RTM grant with tm_fifo_valid=0: streak=0.
  - Any DTM grant: streak=0.
- RUN_x, on entry: watchdog=0; it increments every cycle.
  - Matching done -> csn+1 (modulo 2^32, 0xFFFFFFFF wraps to 0) -> GAP.
  - Else if watchdog == TIMEOUT_CYCLES-1 -> ABORT.
  - done and timeout in the same cycle: done wins. csn increments, no abort.
  - The non-matching done (e.g. dtm_done in RUN_RTM) is ignored.
- ABORT: lasts exactly 1 cycle. timeout_cnt+1, saturating. csn unchanged. Next state GAP.
- GAP: run_* low for GAP_CYCLES cycles, then IDLE. With GAP_CYCLES=0, GAP falls through to IDLE, so that state lasts 1 cycle.
- Done pulses seen in IDLE, ABORT or GAP are ignored; no counter changes.
- enable deasserted mid-run has no effect on the current transaction; it is sampled only in IDLE.
- Request levels are not latched. A request withdrawn before IDLE samples it is not granted.
- Reset mid-run: run_* drop immediately (asynchronously); counters clear.
- Counters:
  - watchdog width = clog2(TIMEOUT_CYCLES)
  - gap counter width = clog2(GAP_CYCLES+1), minimum 1
  - streak counter width = 8

Decomposition:
- Package readout_pkg holds:
  - state encoding constants: IDLE, RUN_RTM, RUN_DTM, ABORT, GAP
  - CSN_W=32 and TOCNT_W=16
  - a clog2 function shared by the three counters
- One sub-module is natural: txn_watchdog. Inputs: clear, enable. Output: expired. Parameter: TIMEOUT_CYCLES.
- The arbitration and streak logic stay in the top module.

Test Plan:
- Reset, then a single ipbus_cmd_valid pulse held 1 cycle in IDLE, with rtm_done 10 cycles later -> run_rtm high 1 cycle after the request for 10 cycles; csn=1; then 2 GAP cycles; busy low afterwards.
- Both requesters held high continuously, each done returned 3 cycles after run, MAX_IPBUS_STREAK=4 -> grant pattern RTM,RTM,RTM,RTM,DTM repeating; csn=10 after 10 transactions.
- RUN_DTM with no done, TIMEOUT_CYCLES=16 -> run_dtm high for 16 cycles, then abort for 1 cycle; timeout_cnt=1; csn unchanged; IDLE after GAP.
- dtm_done in the same cycle the watchdog expires -> no abort; csn increments; timeout_cnt unchanged.
- Preload csn to 0xFFFFFFFF via forced transactions or a backdoor, then complete one transaction -> csn=0x00000000.
- enable=0 with both requests high -> no grant, busy=0. Deassert enable mid-run -> the run completes and no new grant follows. Assert rst mid-run -> run_* and csn are 0 in the same cycle.

Source files
------------

// File: rtl/readout_pkg.sv
// Shared types and constants for the readout scheduler: state encoding,
// counter widths and the width helper used by every counter.
package readout_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN_RTM = 3'd1,
        RUN_DTM = 3'd2,
        ABORT   = 3'd3,
        GAP     = 3'd4
    } state_t;

    localparam int CSN_W    = 32;
    localparam int TOCNT_W  = 16;
    localparam int STREAK_W = 8;

    // Bits needed to hold 0..value-1, never less than one bit.
    function automatic int clog2(input longint unsigned value);
        int bits;
        longint unsigned v;
        bits = 0;
        v = (value > 1) ? value - 1 : 0;
        for (int i = 0; i < 64; i++) begin
            if (v != 0) begin
                bits = bits + 1;
                v = v >> 1;
            end
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/readout_scheduler_if.sv
// Request, completion and status bundle between the two readout paths and
// the scheduler that arbitrates the shared readout engine.
interface readout_scheduler_if;
    import readout_pkg::*;

    logic               enable;
    logic               ipbus_cmd_valid;
    logic               tm_fifo_valid;
    logic               rtm_done;
    logic               dtm_done;
    logic               run_rtm;
    logic               run_dtm;
    logic               abort;
    logic               busy;
    logic [CSN_W-1:0]   csn;
    logic [TOCNT_W-1:0] timeout_cnt;

    modport master (
        output enable, ipbus_cmd_valid, tm_fifo_valid, rtm_done, dtm_done,
        input  run_rtm, run_dtm, abort, busy, csn, timeout_cnt
    );

    modport slave (
        input  enable, ipbus_cmd_valid, tm_fifo_valid, rtm_done, dtm_done,
        output run_rtm, run_dtm, abort, busy, csn, timeout_cnt
    );

endinterface

// File: rtl/readout_scheduler_txn_watchdog.sv
// Transaction watchdog: counts cycles while a run is active and flags the
// last allowed cycle so the scheduler can abort a stuck transaction.
module txn_watchdog
    import readout_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int WD_W = clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] count;

    // Holding at the last value keeps the counter from wrapping if the
    // owner ever lingers; the scheduler leaves RUN on that cycle anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != WD_LAST)) begin
            count <= count + WD_W'(1);
        end
    end

    assign expired = enable && (count == WD_LAST);

endmodule

// File: rtl/readout_scheduler.sv
// Grants the shared readout engine to the IPbus (RTM) or trigger (DTM) path,
// bounds IPbus streaks, watchdogs each run and keeps the command sequence number.
module readout_scheduler
    import readout_pkg::*;
#(
    parameter int unsigned MAX_IPBUS_STREAK = 4,
    parameter int unsigned TIMEOUT_CYCLES   = 65536,
    parameter int unsigned GAP_CYCLES       = 2
) (
    input  logic                clk,
    input  logic                rst,
    readout_scheduler_if.slave  bus
);

    localparam int GAP_W = clog2(GAP_CYCLES + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_IPBUS_STREAK);
    localparam logic [GAP_W-1:0] GAP_LAST =
        (GAP_CYCLES > 1) ? GAP_W'(GAP_CYCLES - 1) : '0;

    state_t               state;
    state_t               next_state;
    logic [STREAK_W-1:0]  streak;
    logic [GAP_W-1:0]     gap_cnt;
    logic [CSN_W-1:0]     csn_q;
    logic [TOCNT_W-1:0]   timeout_q;
    logic                 in_run;
    logic                 done_hit;
    logic                 wd_expired;

    assign in_run   = (state == RUN_RTM) || (state == RUN_DTM);
    assign done_hit = ((state == RUN_RTM) && bus.rtm_done) ||
                      ((state == RUN_DTM) && bus.dtm_done);

    txn_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_run),
        .enable  (in_run),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // IPbus wins ties until its streak reaches the limit; done beats timeout.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.enable) begin
                    if (bus.ipbus_cmd_valid &&
                        (!bus.tm_fifo_valid || (streak < STREAK_MAX))) begin
                        next_state = RUN_RTM;
                    end else if (bus.tm_fifo_valid) begin
                        next_state = RUN_DTM;
                    end
                end
            end
            RUN_RTM, RUN_DTM: begin
                if (done_hit) begin
                    next_state = GAP;
                end else if (wd_expired) begin
                    next_state = ABORT;
                end
            end
            ABORT:   next_state = GAP;
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.run_rtm     = (state == RUN_RTM);
        bus.run_dtm     = (state == RUN_DTM);
        bus.abort       = (state == ABORT);
        bus.busy        = (state != IDLE);
        bus.csn         = csn_q;
        bus.timeout_cnt = timeout_q;
    end

    // The streak only grows while trigger data is actually waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else if ((state == IDLE) && (next_state == RUN_RTM)) begin
            if (!bus.tm_fifo_valid) begin
                streak <= '0;
            end else if (streak < STREAK_MAX) begin
                streak <= streak + STREAK_W'(1);
            end
        end else if ((state == IDLE) && (next_state == RUN_DTM)) begin
            streak <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (state == GAP) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
        end else begin
            gap_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csn_q <= '0;
        end else if (done_hit) begin
            csn_q <= csn_q + CSN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_q <= '0;
        end else if ((state == ABORT) && (timeout_q != '1)) begin
            timeout_q <= timeout_q + TOCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_readout_scheduler.sv
// Scoreboard bench for readout_scheduler: directed requests push expected
// grant/end/abort events, a monitor pops and compares them as they appear.
module tb_readout_scheduler;
    import readout_pkg::*;

    localparam int unsigned MAX_STREAK = 4;
    localparam int unsigned TIMEOUT    = 16;
    localparam int unsigned GAP        = 2;

    typedef enum int {EV_GRANT_RTM, EV_GRANT_DTM, EV_END, EV_ABORT} ev_kind_t;

    typedef struct {
        ev_kind_t    kind;
        logic [31:0] csn;
        logic [15:0] tocnt;
        int          len;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ev_t  exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   done_delay = 0;

    always #5 clk = ~clk;

    readout_scheduler_if sif ();

    readout_scheduler #(
        .MAX_IPBUS_STREAK (MAX_STREAK),
        .TIMEOUT_CYCLES   (TIMEOUT),
        .GAP_CYCLES       (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic ipb, input logic tm);
        @(negedge clk);
        sif.enable          = en;
        sif.ipbus_cmd_valid = ipb;
        sif.tm_fifo_valid   = tm;
    endtask

    function automatic void pushEv(input ev_kind_t k, input logic [31:0] c,
                                   input logic [15:0] t, input int len);
        ev_t e;
        e.kind  = k;
        e.csn   = c;
        e.tocnt = t;
        e.len   = len;
        exp_q.push_back(e);
    endfunction

    task automatic popExpect(input ev_kind_t observed, output ev_t e, output bit ok);
        ok = 1'b0;
        e  = '{EV_END, 32'd0, 16'd0, 0};
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_event: got kind %0d expected none at %0t", observed, $time);
        end else begin
            e = exp_q.pop_front();
            checkOutput("event_kind", longint'(observed), longint'(e.kind));
            ok = 1'b1;
        end
    endtask

    task automatic waitCsn(input logic [31:0] target, input int budget);
        int n = 0;
        while ((sif.csn !== target) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        if (sif.csn !== target) begin
            checks++;
            failures++;
            $display("[TB] FAIL wait_csn: got 0x%0h expected 0x%0h within %0d cycles", sif.csn, target, budget);
        end
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        @(negedge clk);
        while ((sif.busy !== 1'b0) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_idle_busy", sif.busy, 0);
    endtask

    task automatic waitRun(input int budget);
        int n = 0;
        while ((sif.run_rtm !== 1'b1) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_run_rtm", sif.run_rtm, 1);
    endtask

    task automatic doReset();
        rst = 1'b1;
        sif.enable          = 1'b0;
        sif.ipbus_cmd_valid = 1'b0;
        sif.tm_fifo_valid   = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_run_rtm", sif.run_rtm, 0);
        checkOutput("reset_run_dtm", sif.run_dtm, 0);
        checkOutput("reset_abort", sif.abort, 0);
        checkOutput("reset_busy", sif.busy, 0);
        checkOutput("reset_csn", sif.csn, 0);
        checkOutput("reset_timeout_cnt", sif.timeout_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: grants on rising run_*, ends when a run drops without abort.
    initial begin
        logic prev_rtm, prev_dtm, prev_abort, prev_busy;
        int   run_len, abort_len, gap_len;
        ev_t  e;
        bit   ok;
        prev_rtm = 0; prev_dtm = 0; prev_abort = 0; prev_busy = 0;
        run_len = 0; abort_len = 0; gap_len = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rtm = 0; prev_dtm = 0; prev_abort = 0; prev_busy = 0;
                run_len = 0; abort_len = 0; gap_len = 0;
            end else begin
                if (sif.run_rtm && !prev_rtm) begin
                    run_len = 0;
                    popExpect(EV_GRANT_RTM, e, ok);
                end
                if (sif.run_dtm && !prev_dtm) begin
                    run_len = 0;
                    popExpect(EV_GRANT_DTM, e, ok);
                end
                if (sif.run_rtm || sif.run_dtm) run_len++;
                if ((prev_rtm || prev_dtm) && !sif.run_rtm && !sif.run_dtm && !sif.abort) begin
                    popExpect(EV_END, e, ok);
                    if (ok) begin
                        checkOutput("end_csn", sif.csn, e.csn);
                        checkOutput("end_timeout_cnt", sif.timeout_cnt, e.tocnt);
                        checkOutput("end_run_len", run_len, e.len);
                    end
                end
                if (sif.abort) abort_len++;
                if (prev_abort && !sif.abort) begin
                    popExpect(EV_ABORT, e, ok);
                    if (ok) begin
                        checkOutput("abort_csn", sif.csn, e.csn);
                        checkOutput("abort_timeout_cnt", sif.timeout_cnt, e.tocnt);
                        checkOutput("abort_run_len", run_len, e.len);
                        checkOutput("abort_pulse_len", abort_len, 1);
                    end
                    abort_len = 0;
                end
                if (sif.busy && !sif.run_rtm && !sif.run_dtm && !sif.abort) gap_len++;
                if (prev_busy && !sif.busy) begin
                    checkOutput("gap_len", gap_len, GAP);
                    gap_len = 0;
                end
                prev_rtm   = sif.run_rtm;
                prev_dtm   = sif.run_dtm;
                prev_abort = sif.abort;
                prev_busy  = sif.busy;
            end
        end
    end

    // Responder: returns the matching done so the run lasts done_delay cycles.
    initial begin
        logic r_prev, d_prev, is_rtm;
        r_prev = 0; d_prev = 0;
        sif.rtm_done = 1'b0;
        sif.dtm_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && (done_delay > 0) &&
                ((sif.run_rtm && !r_prev) || (sif.run_dtm && !d_prev))) begin
                is_rtm = sif.run_rtm;
                repeat (done_delay - 1) @(negedge clk);
                if (is_rtm) sif.rtm_done = 1'b1;
                else        sif.dtm_done = 1'b1;
                @(negedge clk);
                sif.rtm_done = 1'b0;
                sif.dtm_done = 1'b0;
            end
            r_prev = sif.run_rtm;
            d_prev = sif.run_dtm;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        doReset();

        // Single IPbus command, done on the 10th run cycle.
        done_delay = 10;
        pushEv(EV_GRANT_RTM, 0, 0, 0);
        pushEv(EV_END, 32'd1, 16'd0, 10);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 0, 0);
        checkOutput("t1_grant_latency", sif.run_rtm, 1);
        waitIdle(40);

        // Both paths pending: four IPbus grants, then one trigger grant.
        doReset();
        done_delay = 4;
        for (int i = 0; i < 10; i++) begin
            pushEv(((i % 5) == 4) ? EV_GRANT_DTM : EV_GRANT_RTM, 0, 0, 0);
            pushEv(EV_END, 32'(i + 1), 16'd0, 4);
        end
        applyStimulus(1, 1, 1);
        waitCsn(32'd10, 200);
        applyStimulus(1, 0, 0);
        waitIdle(20);
        checkOutput("t2_csn", sif.csn, 10);

        // Trigger run with no done: abort, and a stray rtm_done is ignored.
        done_delay = 0;
        pushEv(EV_GRANT_DTM, 0, 0, 0);
        pushEv(EV_ABORT, 32'd10, 16'd1, 16);
        applyStimulus(1, 0, 1);
        applyStimulus(1, 0, 0);
        checkOutput("t3_run_dtm", sif.run_dtm, 1);
        @(negedge clk);
        sif.rtm_done = 1'b1;
        @(negedge clk);
        sif.rtm_done = 1'b0;
        waitIdle(60);

        // Done on the cycle the watchdog expires: done wins.
        done_delay = 16;
        pushEv(EV_GRANT_DTM, 0, 0, 0);
        pushEv(EV_END, 32'd11, 16'd1, 16);
        applyStimulus(1, 0, 1);
        applyStimulus(1, 0, 0);
        waitIdle(60);
        checkOutput("t4_timeout_cnt", sif.timeout_cnt, 1);

        // Sequence number wraps from all-ones to zero.
        done_delay = 2;
        @(negedge clk);
        force dut.csn_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.csn_q;
        checkOutput("t5_preload", sif.csn, 32'hFFFF_FFFF);
        pushEv(EV_GRANT_RTM, 0, 0, 0);
        pushEv(EV_END, 32'd0, 16'd1, 2);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 0, 0);
        waitIdle(30);

        // Disabled: no grants. Then disable mid-run: run finishes, nothing follows.
        applyStimulus(0, 1, 1);
        repeat (6) @(negedge clk);
        checkOutput("t6_disabled_busy", sif.busy, 0);
        checkOutput("t6_disabled_run_rtm", sif.run_rtm, 0);
        checkOutput("t6_disabled_run_dtm", sif.run_dtm, 0);
        done_delay = 5;
        pushEv(EV_GRANT_RTM, 0, 0, 0);
        pushEv(EV_END, 32'd1, 16'd1, 5);
        applyStimulus(1, 1, 0);
        @(negedge clk);
        waitRun(10);
        applyStimulus(0, 1, 0);
        waitCsn(32'd1, 40);
        repeat (10) @(negedge clk);
        checkOutput("t6_no_regrant_busy", sif.busy, 0);
        applyStimulus(1, 0, 0);

        // Reset mid-run drops run_rtm and clears counters immediately.
        done_delay = 0;
        pushEv(EV_GRANT_RTM, 0, 0, 0);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 0, 0);
        repeat (3) @(negedge clk);
        checkOutput("t7_pre_reset_run_rtm", sif.run_rtm, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("t7_reset_run_rtm", sif.run_rtm, 0);
        checkOutput("t7_reset_busy", sif.busy, 0);
        checkOutput("t7_reset_csn", sif.csn, 0);
        checkOutput("t7_reset_timeout_cnt", sif.timeout_cnt, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
